alu_exec_stage: RTL and testbench

Execute-stage pipeline wrapper around the combinational Alu. It accepts operand/op bundles over a valid/ready handshake and registers them into stage 1, which drives the Alu inputs directly. It captures the Alu result, compout and overflow into stage 2 and presents them downstream over a second valid/ready handshake. It also keeps a sticky signed-overflow status and a completed-operation counter.

---
 rtl/alu_exec_stage_if.sv | 29 ++
 rtl/alu_exec_stage.sv | 105 ++++++++++
 tb/tb_alu_exec_stage.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_stage_if.sv
// Upstream/downstream valid-ready bundle for alu_exec_stage.
// The slave modport is the stage itself; master is the surrounding producer/consumer.
interface alu_exec_stage_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [OPW-1:0]   in_op;
  logic             in_unsig;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_compout;
  logic             out_overflow;

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_unsig, out_ready,
    output in_ready, out_valid, out_result, out_compout, out_overflow
  );

  modport master (
    output in_valid, in_a, in_b, in_op, in_unsig, out_ready,
    input  in_ready, out_valid, out_result, out_compout, out_overflow
  );
endinterface

// File: rtl/alu_exec_stage.sv
// Two-stage execute wrapper around an external combinational Alu: stage 1 drives the Alu,
// stage 2 holds its result for the downstream handshake; also sticky overflow and op counter.
module alu_exec_stage #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_exec_stage_if.slave  bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  output logic             alu_unsig,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_compout,
  input  logic             alu_overflow,
  input  logic             clr_status,
  output logic             ovf_sticky,
  output logic [CNTW-1:0]  op_count
);

  logic             r_s1_valid;
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [OPW-1:0]   r_alu_op;
  logic             r_alu_unsig;
  logic [WIDTH-1:0] r_out_result;
  logic             r_out_compout;
  logic             r_out_overflow;
  logic             r_ovf_sticky;
  logic [CNTW-1:0]  r_op_count;

  logic w_s2_adv;
  logic w_in_ready;
  logic w_load;
  logic w_out_fire;

  // in_ready looks through stage 2 to out_ready so a full pipe still streams one per cycle
  assign w_s2_adv   = r_s1_valid && (!r_s2_valid || bus.out_ready);
  assign w_in_ready = rst_n && (!r_s1_valid || w_s2_adv);
  assign w_load     = bus.in_valid && w_in_ready;
  assign w_out_fire = r_s2_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid     <= 1'b0;
      r_s2_valid     <= 1'b0;
      r_alu_a        <= '0;
      r_alu_b        <= '0;
      r_alu_op       <= '0;
      r_alu_unsig    <= 1'b0;
      r_out_result   <= '0;
      r_out_compout  <= 1'b0;
      r_out_overflow <= 1'b0;
      r_ovf_sticky   <= 1'b0;
      r_op_count     <= '0;
    end else begin
      if (w_load) begin
        r_alu_a     <= bus.in_a;
        r_alu_b     <= bus.in_b;
        r_alu_op    <= bus.in_op;
        r_alu_unsig <= bus.in_unsig;
        r_s1_valid  <= 1'b1;
      end else if (w_s2_adv) begin
        r_s1_valid  <= 1'b0;
      end

      if (w_s2_adv) begin
        r_out_result   <= alu_out;
        r_out_compout  <= alu_compout;
        r_out_overflow <= alu_overflow;
        r_s2_valid     <= 1'b1;
      end else if (w_out_fire) begin
        r_s2_valid     <= 1'b0;
      end

      // a new signed overflow takes priority over a same-cycle clear
      if (w_s2_adv && alu_overflow && !r_alu_unsig) begin
        r_ovf_sticky <= 1'b1;
      end else if (clr_status) begin
        r_ovf_sticky <= 1'b0;
      end

      if (w_out_fire) begin
        r_op_count <= r_op_count + 1'b1;
      end
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = r_s2_valid;
  assign bus.out_result   = r_out_result;
  assign bus.out_compout  = r_out_compout;
  assign bus.out_overflow = r_out_overflow;

  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_op     = r_alu_op;
  assign alu_unsig  = r_alu_unsig;
  assign ovf_sticky = r_ovf_sticky;
  assign op_count   = r_op_count;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage with a behavioural Alu; expected results are pushed
// on every accepted bundle and popped/compared whenever a result is consumed.
module tb_alu_exec_stage;
  localparam int WIDTH = 32;
  localparam int OPW   = 3;
  localparam int CNTW  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_exec_stage_if #(.WIDTH(WIDTH), .OPW(OPW)) bus_if ();

  logic [WIDTH-1:0] alu_a, alu_b, alu_out;
  logic [OPW-1:0]   alu_op;
  logic             alu_unsig, alu_compout, alu_overflow;
  logic             clr_status;
  logic             ovf_sticky;
  logic [CNTW-1:0]  op_count;

  alu_exec_stage #(.WIDTH(WIDTH), .OPW(OPW), .CNTW(CNTW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus_if),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_unsig    (alu_unsig),
    .alu_out      (alu_out),
    .alu_compout  (alu_compout),
    .alu_overflow (alu_overflow),
    .clr_status   (clr_status),
    .ovf_sticky   (ovf_sticky),
    .op_count     (op_count)
  );

  // Behavioural Alu: {result[33:2], compout[1], overflow[0]}
  function automatic logic [33:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op, input logic u);
    longint     sa, sb, ua, ub, s;
    logic [31:0] r;
    logic        lt, o;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    lt = u ? (ua < ub) : (sa < sb);
    o  = 1'b0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: begin
        s = u ? (ua + ub) : (sa + sb);
        r = s[31:0];
        o = u ? (s > 64'sd4294967295) : (s > 64'sd2147483647 || s < -64'sd2147483648);
      end
      3'd3: r = a ^ b;
      3'd4: r = ~(a | b);
      3'd6: begin
        s = u ? (ua - ub) : (sa - sb);
        r = s[31:0];
        o = u ? (s < 0) : (s > 64'sd2147483647 || s < -64'sd2147483648);
      end
      3'd7: r = {31'd0, lt};
      default: r = a;
    endcase
    return {r, lt, o};
  endfunction

  assign {alu_out, alu_compout, alu_overflow} = ref_alu(alu_a, alu_b, alu_op, alu_unsig);

  int errors = 0;
  int checks = 0;
  logic [33:0]     sbq[$];
  logic [CNTW-1:0] exp_cnt = '0;
  bit              rand_rdy = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus_if.in_valid && bus_if.in_ready)
      sbq.push_back(ref_alu(bus_if.in_a, bus_if.in_b, bus_if.in_op, bus_if.in_unsig));
  end

  always @(negedge clk) begin : mon
    logic [33:0] e;
    if (rst_n && bus_if.out_valid && bus_if.out_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected got=%0h exp=none", bus_if.out_result);
      end else begin
        e = sbq.pop_front();
        check("sb_result",   64'(bus_if.out_result),   64'(e[33:2]));
        check("sb_compout",  64'(bus_if.out_compout),  64'(e[1]));
        check("sb_overflow", 64'(bus_if.out_overflow), 64'(e[0]));
        check("sb_op_count", 64'(op_count),            64'(exp_cnt));
      end
      exp_cnt = exp_cnt + 1'b1;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_rdy) bus_if.out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] op, input logic u);
    int n = 0;
    bus_if.in_a     = a;
    bus_if.in_b     = b;
    bus_if.in_op    = op;
    bus_if.in_unsig = u;
    bus_if.in_valid = 1'b1;
    @(negedge clk);
    while (!bus_if.in_ready) begin
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout got=stalled exp=accept");
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while (sbq.size() != 0 || bus_if.out_valid) begin
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL drain_timeout got=%0d exp=0", sbq.size());
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus_if.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sbq.delete();
    exp_cnt = '0;
  endtask

  task automatic pulse_clr();
    clr_status = 1'b1;
    @(posedge clk);
    #1;
    clr_status = 1'b0;
  endtask

  initial begin
    bus_if.in_valid  = 1'b0;
    bus_if.in_a      = '0;
    bus_if.in_b      = '0;
    bus_if.in_op     = '0;
    bus_if.in_unsig  = 1'b0;
    bus_if.out_ready = 1'b1;
    clr_status       = 1'b0;

    // reset state, with in_valid high to show in_ready is forced low
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b1;
    @(negedge clk);
    check("rst_in_ready",   64'(bus_if.in_ready),   64'(0));
    check("rst_out_valid",  64'(bus_if.out_valid),  64'(0));
    check("rst_out_result", 64'(bus_if.out_result), 64'(0));
    check("rst_alu_a",      64'(alu_a),             64'(0));
    check("rst_op_count",   64'(op_count),          64'(0));
    check("rst_sticky",     64'(ovf_sticky),        64'(0));
    @(posedge clk);
    #1;
    do_reset();

    // single add and latency
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b010, 1'b0);
    @(negedge clk);
    check("t1_valid_early", 64'(bus_if.out_valid), 64'(0));
    @(negedge clk);
    check("t1_valid", 64'(bus_if.out_valid), 64'(1));
    check("t1_result", 64'(bus_if.out_result), 64'h0FFFFFFFE);
    @(posedge clk);
    #1;
    drain();
    check("t1_op_count", 64'(op_count), 64'(1));
    check("t1_sticky", 64'(ovf_sticky), 64'(0));

    // signed overflow, clear, unsigned never sets sticky
    send(32'h7FFFFFFF, 32'h00000001, 3'b010, 1'b0);
    drain();
    check("t2_sticky_set", 64'(ovf_sticky), 64'(1));
    pulse_clr();
    @(negedge clk);
    check("t2_sticky_clr", 64'(ovf_sticky), 64'(0));
    @(posedge clk);
    #1;
    send(32'h7FFFFFFF, 32'h00000001, 3'b010, 1'b1);
    send(32'hFFFFFFFF, 32'h00000001, 3'b010, 1'b1);
    drain();
    check("t2_sticky_unsig", 64'(ovf_sticky), 64'(0));

    // back-pressure
    do_reset();
    bus_if.out_ready = 1'b0;
    send(32'd1, 32'd10, 3'b010, 1'b0);
    send(32'd2, 32'd20, 3'b010, 1'b0);
    bus_if.in_a = 32'd3; bus_if.in_b = 32'd30; bus_if.in_valid = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t3_in_ready", 64'(bus_if.in_ready), 64'(0));
      check("t3_out_valid", 64'(bus_if.out_valid), 64'(1));
      check("t3_hold_result", 64'(bus_if.out_result), 64'(11));
      check("t3_hold_alu_a", 64'(alu_a), 64'(2));
      @(posedge clk);
      #1;
    end
    bus_if.out_ready = 1'b1;
    send(32'd3, 32'd30, 3'b010, 1'b0);
    send(32'd4, 32'd40, 3'b010, 1'b0);
    send(32'd5, 32'd50, 3'b010, 1'b0);
    drain();
    check("t3_op_count", 64'(op_count), 64'(5));

    // full throughput
    for (int unsigned i = 0; i <= 10; i++) begin
      if (i < 8) begin
        bus_if.in_a = 32'(i * 3 + 1); bus_if.in_b = 32'(i * 100);
        bus_if.in_op = 3'b010; bus_if.in_unsig = 1'b0; bus_if.in_valid = 1'b1;
      end else begin
        bus_if.in_valid = 1'b0;
      end
      @(negedge clk);
      if (i < 8) check("t4_in_ready", 64'(bus_if.in_ready), 64'(1));
      check("t4_out_valid", 64'(bus_if.out_valid), 64'((i >= 2 && i <= 9) ? 1 : 0));
      @(posedge clk);
      #1;
    end
    drain();

    // randomized traffic with random back-pressure
    rand_rdy = 1'b1;
    for (int unsigned i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(($urandom_range(0, 7) == 0) ? 32'h7FFFFFFF : $urandom,
           ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom,
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end
    rand_rdy = 1'b0;
    bus_if.out_ready = 1'b1;
    drain();

    // reset mid-flight
    pulse_clr();
    bus_if.out_ready = 1'b0;
    send(32'h7FFFFFFF, 32'h00000001, 3'b010, 1'b0);
    send(32'd5, 32'd6, 3'b010, 1'b0);
    @(negedge clk);
    check("t5_pre_sticky", 64'(ovf_sticky), 64'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus_if.out_ready = 1'b1;
    bus_if.in_valid = 1'b1;
    @(negedge clk);
    check("t5_rst_in_ready", 64'(bus_if.in_ready), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus_if.in_valid = 1'b0;
    sbq.delete();
    exp_cnt = '0;
    @(negedge clk);
    check("t5_op_count", 64'(op_count), 64'(0));
    check("t5_sticky", 64'(ovf_sticky), 64'(0));
    for (int unsigned k = 0; k < 5; k++) begin
      check("t5_no_stale", 64'(bus_if.out_valid), 64'(0));
      @(negedge clk);
    end
    @(posedge clk);
    #1;

    // set/clear collision: set wins
    pulse_clr();
    send(32'h7FFFFFFF, 32'h00000001, 3'b010, 1'b0);
    clr_status = 1'b1;
    @(posedge clk);
    #1;
    clr_status = 1'b0;
    @(negedge clk);
    check("t6_set_wins", 64'(ovf_sticky), 64'(1));
    @(posedge clk);
    #1;
    drain();

    // counter wrap
    do_reset();
    for (int unsigned i = 0; i < 65535; i++)
      send($urandom, $urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    drain();
    check("t6_cnt_max", 64'(op_count), 64'h0FFFF);
    send(32'd7, 32'd8, 3'b010, 1'b0);
    drain();
    check("t6_cnt_wrap", 64'(op_count), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
